// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register.
// State encodings double as the occupancy count reported on occ_o.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

endpackage : pipe_pkg

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with an optional skid entry and hold/flush
// flow control. It replaces the hand-written IF/ID, ID/EX, EX/MEM and MEM/WB registers.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int SKID       = 1,
  parameter int CLEAR_DATA = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fc_flush_i,
  input  logic              fc_bk_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
  output logic [1:0]        occ_o
);

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;

  logic w_up_ready;
  logic w_dn_valid;
  logic w_up_fire;
  logic w_dn_fire;

  assign w_dn_valid = (r_state != ST_EMPTY) && !fc_bk_i;

  // With the skid entry, upstream ready depends only on local state, so the
  // dn_ready_i -> up_ready_o combinational path is cut.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign w_up_ready = !rst && !fc_bk_i && (r_state != ST_TWO);
    end else begin : g_pass_ready
      assign w_up_ready = !rst && !fc_bk_i && (!w_dn_valid || dn_ready_i);
    end
  endgenerate

  assign w_up_fire = up_valid_i && w_up_ready;
  assign w_dn_fire = w_dn_valid && dn_ready_i;

  // NOTE: the payload registers are only cleared when CLEAR_DATA is set; leaving them
  // out of reset otherwise lets synthesis use plain (non-resettable) flops for wide payloads.
  always_ff @(posedge clk) begin
    if (rst || fc_flush_i) begin
      r_state <= ST_EMPTY;
      if (CLEAR_DATA != 0) begin
        r_main <= '0;
        r_skid <= '0;
      end
    end else if (!fc_bk_i) begin
      case (r_state)
        ST_EMPTY: begin
          if (w_up_fire) begin
            r_state <= ST_ONE;
            r_main  <= up_data_i;
          end
        end
        ST_ONE: begin
          if (w_up_fire && w_dn_fire) begin
            r_main <= up_data_i;
          end else if (w_up_fire && (SKID != 0)) begin
            r_state <= ST_TWO;
            r_skid  <= up_data_i;
          end else if (w_dn_fire) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_dn_fire) begin
            r_state <= ST_ONE;
            r_main  <= r_skid;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign up_ready_o = w_up_ready;
  assign dn_valid_o = w_dn_valid;
  assign dn_data_o  = r_main;
  assign occ_o      = r_state;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a SKID=1 instance for reset/stream/backpressure/
// hold/flush and a SKID=0 instance for the combinational-ready variant.
module tb_pipe_stage_reg;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         fc_flush, fc_bk, up_valid, dn_ready;
  logic [W-1:0] up_data;
  logic         up_ready, dn_valid;
  logic [W-1:0] dn_data;
  logic [1:0]   occ;

  logic         fc_flush0, fc_bk0, up_valid0, dn_ready0;
  logic [W-1:0] up_data0;
  logic         up_ready0, dn_valid0;
  logic [W-1:0] dn_data0;
  logic [1:0]   occ0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(W), .SKID(1), .CLEAR_DATA(1)) dut (
    .clk(clk), .rst(rst), .fc_flush_i(fc_flush), .fc_bk_i(fc_bk),
    .up_valid_i(up_valid), .up_ready_o(up_ready), .up_data_i(up_data),
    .dn_valid_o(dn_valid), .dn_ready_i(dn_ready), .dn_data_o(dn_data), .occ_o(occ)
  );

  pipe_stage_reg #(.DATA_W(W), .SKID(0), .CLEAR_DATA(1)) dut0 (
    .clk(clk), .rst(rst), .fc_flush_i(fc_flush0), .fc_bk_i(fc_bk0),
    .up_valid_i(up_valid0), .up_ready_o(up_ready0), .up_data_i(up_data0),
    .dn_valid_o(dn_valid0), .dn_ready_i(dn_ready0), .dn_data_o(dn_data0), .occ_o(occ0)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge, then let combinational outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; fc_flush = 1'b0; fc_bk = 1'b0; up_valid = 1'b1; dn_ready = 1'b0;
    up_data = 32'hDEAD_BEEF;
    fc_flush0 = 1'b0; fc_bk0 = 1'b0; up_valid0 = 1'b0; dn_ready0 = 1'b0; up_data0 = '0;

    // Reset held two cycles with valid input present
    tick();
    tick();
    settle();
    check("rst_dn_valid", {31'd0, dn_valid}, 32'd0);
    check("rst_dn_data",  dn_data, 32'd0);
    check("rst_occ",      {30'd0, occ}, 32'd0);
    check("rst_up_ready", {31'd0, up_ready}, 32'd0);
    check("rst_occ_skid0", {30'd0, occ0}, 32'd0);
    rst = 1'b0;
    up_valid = 1'b0;

    // Streaming 1..8 with downstream always ready
    dn_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      up_valid = (c < 8);
      up_data  = 32'(c + 1);
      settle();
      check("str_up_ready", {31'd0, up_ready}, 32'd1);
      check("str_dn_valid", {31'd0, dn_valid}, (c >= 1 && c <= 8) ? 32'd1 : 32'd0);
      check("str_occ",      {30'd0, occ},      (c >= 1 && c <= 8) ? 32'd1 : 32'd0);
      if (c >= 1 && c <= 8) check("str_dn_data", dn_data, 32'(c));
      tick();
    end
    up_valid = 1'b0;

    // Backpressure fills both entries
    dn_ready = 1'b0;
    up_valid = 1'b1; up_data = 32'hA;
    settle();
    check("bp_ready_a", {31'd0, up_ready}, 32'd1);
    tick();
    up_data = 32'hB;
    settle();
    check("bp_ready_b", {31'd0, up_ready}, 32'd1);
    check("bp_head_a",  dn_data, 32'hA);
    tick();
    up_valid = 1'b0;
    settle();
    check("bp_occ2",     {30'd0, occ}, 32'd2);
    check("bp_ready0",   {31'd0, up_ready}, 32'd0);
    check("bp_out_a_v",  {31'd0, dn_valid}, 32'd1);
    check("bp_out_a",    dn_data, 32'hA);
    dn_ready = 1'b1;
    settle();
    check("bp_ready_at_fire", {31'd0, up_ready}, 32'd0);
    tick();
    settle();
    check("bp_ready_after", {31'd0, up_ready}, 32'd1);
    check("bp_out_b",       dn_data, 32'hB);
    check("bp_out_b_v",     {31'd0, dn_valid}, 32'd1);
    check("bp_occ1",        {30'd0, occ}, 32'd1);
    tick();
    settle();
    check("bp_occ0", {30'd0, occ}, 32'd0);

    // Hold with one entry of 0x55
    dn_ready = 1'b0; up_valid = 1'b1; up_data = 32'h55;
    tick();
    fc_bk = 1'b1; dn_ready = 1'b1; up_data = 32'h99;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("hold_dn_valid", {31'd0, dn_valid}, 32'd0);
      check("hold_dn_data",  dn_data, 32'h55);
      check("hold_occ",      {30'd0, occ}, 32'd1);
      check("hold_up_ready", {31'd0, up_ready}, 32'd0);
      tick();
    end
    fc_bk = 1'b0; up_valid = 1'b0;
    settle();
    check("hold_rel_valid", {31'd0, dn_valid}, 32'd1);
    check("hold_rel_data",  dn_data, 32'h55);
    tick();
    settle();
    check("hold_rel_occ0", {30'd0, occ}, 32'd0);

    // Flush during hold with two entries held
    dn_ready = 1'b0; up_valid = 1'b1; up_data = 32'h11;
    tick();
    up_data = 32'h22;
    tick();
    settle();
    check("fl_occ2", {30'd0, occ}, 32'd2);
    fc_flush = 1'b1; fc_bk = 1'b1; up_data = 32'h33;
    tick();
    fc_flush = 1'b0; fc_bk = 1'b0; up_valid = 1'b0;
    settle();
    check("fl_occ0",     {30'd0, occ}, 32'd0);
    check("fl_dn_valid", {31'd0, dn_valid}, 32'd0);
    check("fl_dn_data",  dn_data, 32'd0);
    tick();
    settle();
    check("fl_no_capture", {30'd0, occ}, 32'd0);

    // SKID=0: toggling downstream ready with continuous input; payload index advances
    // only on the cycles where the stage is expected to accept.
    up_valid0 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      dn_ready0 = ((c % 2) == 0);
      up_data0  = 32'h100 + 32'((c + 1) / 2);
      settle();
      check("s0_up_ready", {31'd0, up_ready0}, (c == 0 || (c % 2) == 0) ? 32'd1 : 32'd0);
      check("s0_dn_valid", {31'd0, dn_valid0}, (c >= 1) ? 32'd1 : 32'd0);
      if (c >= 1) check("s0_dn_data", dn_data0, 32'h100 + 32'((c - 1) / 2));
      tick();
    end
    up_valid0 = 1'b0; dn_ready0 = 1'b1;
    settle();
    check("s0_last_data",  dn_data0, 32'h103);
    check("s0_last_valid", {31'd0, dn_valid0}, 32'd1);
    tick();
    settle();
    check("s0_drained", {31'd0, dn_valid0}, 32'd0);
    check("s0_occ0",    {30'd0, occ0}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pipe_stage_reg
